// File: rtl/wm_pkg.sv
// Shared types and width helpers for the watermark proof sequencer.
// Latency/backpressure: none (declarations only).
package wm_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      FRAME = 2'd1,
      SEND  = 2'd2,
      LOCK  = 2'd3
   } wm_state_t;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to index n items, never less than one.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wm_sig_tx.sv
// Serializes SIGN into OUT_W beats MSB-first; first beat valid 1 cycle after i_start.
// Beats hold while i_ready is low; o_done pulses combinationally on the final accept.
module wm_sig_tx #(
   parameter int                SIGN_W = 80,
   parameter logic [SIGN_W-1:0] SIGN   = 80'h4C41424F5F49445F574D,
   parameter int                OUT_W  = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [OUT_W-1:0] o_data,
   output logic             o_last,
   output logic             o_done
);
   import wm_pkg::*;

   localparam int N_BEATS = SIGN_W / OUT_W;
   localparam int IDX_W   = idx_w(N_BEATS);

   logic             r_valid;
   logic [OUT_W-1:0] r_data;
   logic             r_last;
   logic [IDX_W-1:0] r_idx;
   logic             w_accept;

   function automatic logic [OUT_W-1:0] beat(input int i);
      return SIGN[SIGN_W-1-i*OUT_W -: OUT_W];
   endfunction

   assign w_accept = r_valid & i_ready;
   assign o_done   = w_accept & r_last;
   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_last   = r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_idx   <= '0;
      end else if (i_start) begin
         r_valid <= 1'b1;
         r_data  <= beat(0);
         r_last  <= (N_BEATS == 1);
         r_idx   <= '0;
      end else if (w_accept) begin
         if (r_last) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
         end else begin
            r_idx  <= r_idx + IDX_W'(1);
            r_data <= beat(int'(r_idx) + 1);
            r_last <= ((int'(r_idx) + 2) == N_BEATS);
         end
      end
   end

endmodule

// File: rtl/wm_proof_seq.sv
// Ownership-proof responder: ordered serial keys unlock a signature stream, repeated failures lock out.
// Signature beat valid 1 cycle after the completing bit; beats hold under sig_ready low, tr_we ignored in SEND/LOCK.
module wm_proof_seq #(
   parameter int                       KEY_W    = 64,
   parameter int                       N_KEYS   = 2,
   parameter logic [N_KEYS*KEY_W-1:0]  KEYS     = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210},
   parameter int                       SIGN_W   = 80,
   parameter logic [SIGN_W-1:0]        SIGN     = 80'h4C41424F5F49445F574D,
   parameter int                       OUT_W    = 16,
   parameter int                       TIMEOUT  = 4096,
   parameter int                       MAX_FAIL = 3,
   parameter int                       LOCK_CYC = 65536
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tr_we,
   input  logic             tr_bit,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic [OUT_W-1:0] sig_data,
   output logic             sig_last,
   output logic             sig_locked,
   output logic             fail_pulse
);
   import wm_pkg::*;

   localparam int BC_W  = cnt_w(KEY_W);
   localparam int TO_W  = cnt_w(TIMEOUT);
   localparam int LK_W  = cnt_w(LOCK_CYC);
   localparam int STG_W = idx_w(N_KEYS);
   localparam int FC_W  = cnt_w(MAX_FAIL);

   wm_state_t        r_state, w_state_nxt;
   logic [KEY_W-1:0] r_sr, w_sr_nxt;
   logic [STG_W-1:0] r_stage, w_stage_nxt;
   logic [BC_W-1:0]  r_bitcnt, w_bitcnt_nxt;
   logic [TO_W-1:0]  r_idle, w_idle_nxt;
   logic [LK_W-1:0]  r_lock, w_lock_nxt;
   logic [FC_W-1:0]  r_fail_cnt, w_fail_cnt_nxt;
   logic             r_fail_pulse;

   logic [KEY_W-1:0] w_shift;
   logic [KEY_W-1:0] w_key_cur;
   logic [FC_W-1:0]  w_fail_inc;
   logic             w_fail;
   logic             w_start;
   logic             w_done;

   assign w_shift    = {r_sr[KEY_W-2:0], tr_bit};
   assign w_key_cur  = KEYS[int'(r_stage)*KEY_W +: KEY_W];
   assign w_fail_inc = r_fail_cnt + FC_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= HUNT;
         r_sr         <= '0;
         r_stage      <= '0;
         r_bitcnt     <= '0;
         r_idle       <= '0;
         r_lock       <= '0;
         r_fail_cnt   <= '0;
         r_fail_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sr         <= w_sr_nxt;
         r_stage      <= w_stage_nxt;
         r_bitcnt     <= w_bitcnt_nxt;
         r_idle       <= w_idle_nxt;
         r_lock       <= w_lock_nxt;
         r_fail_cnt   <= w_fail_cnt_nxt;
         r_fail_pulse <= w_fail;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sr_nxt       = r_sr;
      w_stage_nxt    = r_stage;
      w_bitcnt_nxt   = r_bitcnt;
      w_idle_nxt     = r_idle;
      w_lock_nxt     = r_lock;
      w_fail_cnt_nxt = r_fail_cnt;
      w_fail         = 1'b0;
      w_start        = 1'b0;

      case (r_state)
         HUNT: begin
            // Sliding window on stage 0: misses here are not counted as failures.
            if (tr_we) begin
               w_sr_nxt = w_shift;
               if (w_shift == KEYS[KEY_W-1:0]) begin
                  if (N_KEYS == 1) begin
                     w_state_nxt = SEND;
                     w_start     = 1'b1;
                  end else begin
                     w_state_nxt  = FRAME;
                     w_stage_nxt  = STG_W'(1);
                     w_bitcnt_nxt = '0;
                     w_idle_nxt   = '0;
                  end
               end
            end
         end

         FRAME: begin
            if (tr_we) begin
               w_sr_nxt   = w_shift;
               w_idle_nxt = '0;
               if (r_bitcnt == BC_W'(KEY_W - 1)) begin
                  if (w_shift != w_key_cur) begin
                     w_fail = 1'b1;
                  end else if (r_stage == STG_W'(N_KEYS - 1)) begin
                     w_state_nxt = SEND;
                     w_start     = 1'b1;
                  end else begin
                     w_stage_nxt  = r_stage + STG_W'(1);
                     w_bitcnt_nxt = '0;
                  end
               end else begin
                  w_bitcnt_nxt = r_bitcnt + BC_W'(1);
               end
            end else if (r_idle == TO_W'(TIMEOUT - 1)) begin
               w_fail = 1'b1;
            end else begin
               w_idle_nxt = r_idle + TO_W'(1);
            end
         end

         SEND: begin
            if (w_done) begin
               w_state_nxt    = HUNT;
               w_sr_nxt       = '0;
               w_stage_nxt    = '0;
               w_bitcnt_nxt   = '0;
               w_idle_nxt     = '0;
               w_fail_cnt_nxt = '0;
            end
         end

         LOCK: begin
            if (r_lock == LK_W'(LOCK_CYC - 1)) begin
               w_state_nxt    = HUNT;
               w_lock_nxt     = '0;
               w_fail_cnt_nxt = '0;
            end else begin
               w_lock_nxt = r_lock + LK_W'(1);
            end
         end

         default: w_state_nxt = HUNT;
      endcase

      if (w_fail) begin
         w_sr_nxt     = '0;
         w_stage_nxt  = '0;
         w_bitcnt_nxt = '0;
         w_idle_nxt   = '0;
         w_lock_nxt   = '0;
         if (w_fail_inc == FC_W'(MAX_FAIL)) begin
            w_state_nxt    = LOCK;
            w_fail_cnt_nxt = w_fail_inc;
         end else begin
            w_state_nxt    = HUNT;
            w_fail_cnt_nxt = w_fail_inc;
         end
      end
   end

   assign sig_locked = (r_state == LOCK);
   assign fail_pulse = r_fail_pulse;

   wm_sig_tx #(
      .SIGN_W (SIGN_W),
      .SIGN   (SIGN),
      .OUT_W  (OUT_W)
   ) u_sig_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_ready (sig_ready),
      .o_valid (sig_valid),
      .o_data  (sig_data),
      .o_last  (sig_last),
      .o_done  (w_done)
   );

endmodule
